// File: rtl/multichannel_biquad_pkg.sv
// Shared types, coefficient tables and fixed-point helpers for the
// multichannel biquad. Coefficients are Q4.14 and sized by COEF_W.
package biquad_pkg;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 18;
    localparam int COEF_FRAC = 14;
    localparam int SEL_W     = 3;
    localparam int ACC_W     = DATA_W + COEF_W + 3;

    typedef struct packed {
        logic signed [COEF_W-1:0] b0;
        logic signed [COEF_W-1:0] b1;
        logic signed [COEF_W-1:0] b2;
        logic signed [COEF_W-1:0] a1;
        logic signed [COEF_W-1:0] a2;
    } coef_t;

    typedef enum logic [1:0] {
        BYPASS   = 2'd0,
        LOWPASS  = 2'd1,
        HIGHPASS = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam coef_t COEF_UNITY = '{18'sd16384, 18'sd0, 18'sd0, 18'sd0, 18'sd0};

    // Lowpass entries 1..6 use a real double pole (0.75 down to 0) with unity
    // DC gain; entry 7 is a flat x4 gain used to exercise output clamping.
    localparam coef_t COEF_LP [2**SEL_W] = '{
        '{18'sd16384, 18'sd0,     18'sd0,     18'sd0,      18'sd0},
        '{18'sd256,   18'sd512,   18'sd256,   -18'sd24576, 18'sd9216},
        '{18'sd576,   18'sd1152,  18'sd576,   -18'sd20480, 18'sd6400},
        '{18'sd1024,  18'sd2048,  18'sd1024,  -18'sd16384, 18'sd4096},
        '{18'sd1600,  18'sd3200,  18'sd1600,  -18'sd12288, 18'sd2304},
        '{18'sd2304,  18'sd4608,  18'sd2304,  -18'sd8192,  18'sd1024},
        '{18'sd4096,  18'sd8192,  18'sd4096,  18'sd0,      18'sd0},
        '{18'sd65536, 18'sd0,     18'sd0,     18'sd0,      18'sd0}
    };

    // Highpass entries share the lowpass poles; numerator k*(1,-2,1) gives an
    // exact DC zero and unity gain at Nyquist.
    localparam coef_t COEF_HP [2**SEL_W] = '{
        '{18'sd16384, 18'sd0,      18'sd0,     18'sd0,      18'sd0},
        '{18'sd12544, -18'sd25088, 18'sd12544, -18'sd24576, 18'sd9216},
        '{18'sd10816, -18'sd21632, 18'sd10816, -18'sd20480, 18'sd6400},
        '{18'sd9216,  -18'sd18432, 18'sd9216,  -18'sd16384, 18'sd4096},
        '{18'sd7744,  -18'sd15488, 18'sd7744,  -18'sd12288, 18'sd2304},
        '{18'sd6400,  -18'sd12800, 18'sd6400,  -18'sd8192,  18'sd1024},
        '{18'sd4096,  -18'sd8192,  18'sd4096,  18'sd0,      18'sd0},
        '{18'sd65536, 18'sd0,      18'sd0,     18'sd0,      18'sd0}
    };

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(1 << (DATA_W - 1)));

    // Round half up, drop the fractional bits, clamp to the sample range.
    function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = (acc + RND_HALF) >>> COEF_FRAC;
        if (r > SAT_MAX) begin
            return DATA_W'(SAT_MAX);
        end
        if (r < SAT_MIN) begin
            return DATA_W'(SAT_MIN);
        end
        return DATA_W'(r);
    endfunction

    // Mode codes 0 and 3 both pass samples straight through.
    function automatic logic is_bypass(input logic [1:0] m);
        return !((m == LOWPASS) || (m == HIGHPASS));
    endfunction

endpackage

// File: rtl/multichannel_biquad_if.sv
// Sample-frame handshake between the source, the biquad and the gain stage.
interface multichannel_biquad_if #(
    parameter int NUM_CH = 2
) ();

    logic [1:0]                                 mode;
    logic [biquad_pkg::SEL_W-1:0]               filter;
    logic                                       in_valid;
    logic                                       in_ready;
    logic [NUM_CH*biquad_pkg::DATA_W-1:0]       in_data;
    logic                                       out_valid;
    logic [NUM_CH*biquad_pkg::DATA_W-1:0]       out_data;

    modport master (
        output mode, filter, in_valid, in_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  mode, filter, in_valid, in_data,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/multichannel_biquad_coef_rom.sv
// Combinational coefficient lookup keyed by the latched {mode, filter}.
module biquad_coef_rom
    import biquad_pkg::*;
(
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] filter,
    output coef_t            coef
);

    // Bypass codes get unity; the datapath ignores the MAC result then anyway.
    always_comb begin
        coef = COEF_UNITY;
        if (mode == LOWPASS) begin
            coef = COEF_LP[filter];
        end else if (mode == HIGHPASS) begin
            coef = COEF_HP[filter];
        end
    end

endmodule

// File: rtl/multichannel_biquad.sv
// Time-multiplexed Direct Form I biquad: one channel per CALC cycle, a
// single shared MAC, per-channel x/y histories and a frame handshake.
module multichannel_biquad
    import biquad_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic                 clk_144,
    input  logic                 reset_n,
    multichannel_biquad_if.slave bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef logic signed [DATA_W-1:0] sample_t;

    state_t                     state_reg, state_next;
    logic [CH_W-1:0]            ch_reg, ch_next;
    logic [NUM_CH*DATA_W-1:0]   frame_data_reg;
    logic [SEL_W+1:0]           frame_sel_reg;
    logic                       hist_clr_reg;
    sample_t                    x1_reg  [NUM_CH];
    sample_t                    x2_reg  [NUM_CH];
    sample_t                    y1_reg  [NUM_CH];
    sample_t                    y2_reg  [NUM_CH];
    sample_t                    out_reg [NUM_CH];
    logic [NUM_CH*DATA_W-1:0]   out_packed;

    logic                       ready;
    logic                       pulse;
    logic                       accept;
    logic                       bypass;
    coef_t                      coef;
    sample_t                    x_cur, x1_eff, x2_eff, y1_eff, y2_eff, y_filt, y_cur;
    logic signed [ACC_W-1:0]    acc;

    assign accept        = bus.in_valid & ready;
    assign bus.in_ready  = ready;
    assign bus.out_valid = pulse;
    assign bus.out_data  = out_packed;

    // State and channel counter registers.
    always_ff @(posedge clk_144 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            ch_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
        end
    end

    // Next-state logic; OUT also accepts so frames can stream back to back.
    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        ready      = 1'b0;
        pulse      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = S_CALC;
                    ch_next    = '0;
                end
            end
            S_CALC: begin
                if (ch_reg == LAST_CH) begin
                    state_next = S_OUT;
                end else begin
                    ch_next = ch_reg + 1'b1;
                end
            end
            S_OUT: begin
                ready = 1'b1;
                pulse = 1'b1;
                if (bus.in_valid) begin
                    state_next = S_CALC;
                    ch_next    = '0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                ch_next    = '0;
            end
        endcase
    end

    biquad_coef_rom u_coef_rom (
        .mode   (frame_sel_reg[SEL_W+1:SEL_W]),
        .filter (frame_sel_reg[SEL_W-1:0]),
        .coef   (coef)
    );

    // Shared MAC for the channel selected by ch_reg; a changed {mode, filter}
    // masks the stored histories so the new response starts from rest.
    always_comb begin
        x_cur  = frame_data_reg[ch_reg*DATA_W +: DATA_W];
        x1_eff = hist_clr_reg ? '0 : x1_reg[ch_reg];
        x2_eff = hist_clr_reg ? '0 : x2_reg[ch_reg];
        y1_eff = hist_clr_reg ? '0 : y1_reg[ch_reg];
        y2_eff = hist_clr_reg ? '0 : y2_reg[ch_reg];
        acc    = ACC_W'($signed(coef.b0)) * ACC_W'(x_cur)
               + ACC_W'($signed(coef.b1)) * ACC_W'(x1_eff)
               + ACC_W'($signed(coef.b2)) * ACC_W'(x2_eff)
               - ACC_W'($signed(coef.a1)) * ACC_W'(y1_eff)
               - ACC_W'($signed(coef.a2)) * ACC_W'(y2_eff);
        y_filt = sat_round(acc);
        bypass = is_bypass(frame_sel_reg[SEL_W+1:SEL_W]);
        y_cur  = bypass ? x_cur : y_filt;
    end

    // Frame capture on handshake; per-channel history and output update in CALC.
    always_ff @(posedge clk_144 or negedge reset_n) begin
        if (!reset_n) begin
            frame_data_reg <= '0;
            frame_sel_reg  <= '0;
            hist_clr_reg   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                x1_reg[i]  <= '0;
                x2_reg[i]  <= '0;
                y1_reg[i]  <= '0;
                y2_reg[i]  <= '0;
                out_reg[i] <= '0;
            end
        end else begin
            if (accept) begin
                frame_data_reg <= bus.in_data;
                frame_sel_reg  <= {bus.mode, bus.filter};
                hist_clr_reg   <= ({bus.mode, bus.filter} != frame_sel_reg);
            end
            if (state_reg == S_CALC) begin
                out_reg[ch_reg] <= y_cur;
                if (bypass) begin
                    x1_reg[ch_reg] <= '0;
                    x2_reg[ch_reg] <= '0;
                    y1_reg[ch_reg] <= '0;
                    y2_reg[ch_reg] <= '0;
                end else begin
                    x2_reg[ch_reg] <= x1_eff;
                    x1_reg[ch_reg] <= x_cur;
                    y2_reg[ch_reg] <= y1_eff;
                    y1_reg[ch_reg] <= y_cur;
                end
            end
        end
    end

    // Channel 0 lands in the least significant slice.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
        assign out_packed[gi*DATA_W +: DATA_W] = out_reg[gi];
    end

endmodule

// File: tb/tb_multichannel_biquad.sv
// Directed bench for multichannel_biquad (NUM_CH=2): reset, bypass latency,
// lowpass impulse, highpass DC rejection, clamping, streaming and async abort.
module tb_multichannel_biquad;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    localparam logic signed [15:0] S_MAX = 16'sh7FFF;
    localparam logic signed [15:0] S_MIN = 16'sh8000;

    always #5 clk = ~clk;

    multichannel_biquad_if #(.NUM_CH(2)) bus ();

    multichannel_biquad #(.NUM_CH(2)) dut (
        .clk_144 (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // One filter step with round-half-up and clamping.
    function automatic longint ref_step(input longint b0, b1, b2, a1, a2,
                                        input longint x, x1, x2, y1, y2);
        longint acc, r;
        acc = b0 * x + b1 * x1 + b2 * x2 - a1 * y1 - a2 * y2;
        r   = (acc + 64'sd8192) >>> 14;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Presents one frame, waits for the handshake and for out_valid.
    // lat counts cycles after the accept edge; 10 means it never came.
    task automatic run_frame(input logic [1:0] m, input logic [2:0] f,
                             input logic signed [15:0] d0, input logic signed [15:0] d1,
                             output logic signed [15:0] y0, output logic signed [15:0] y1,
                             output int lat);
        int wait_n;
        bus.mode     = m;
        bus.filter   = f;
        bus.in_data  = {d1, d0};
        bus.in_valid = 1'b1;
        wait_n = 0;
        while (!bus.in_ready && wait_n < 10) begin
            @(posedge clk); #1;
            wait_n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        y0 = bus.out_data[15:0];
        y1 = bus.out_data[31:16];
        $display("frame mode=%0d filter=%0d in=(%0d,%0d) out=(%0d,%0d) lat=%0d",
                 m, f, d0, d1, y0, y1, lat);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.mode     = 2'd0;
        bus.filter   = 3'd0;
        bus.in_data  = '0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b valid=%b data=%h, want 1 0 00000000",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: ready=%b valid=%b data=%h, want 1 0 00000000",
                         c, bus.in_ready, bus.out_valid, bus.out_data);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_bp;
        int extra;
        exp_bp       = {16'hEF4B, 16'h10B5};
        bus.mode     = 2'd0;
        bus.filter   = 3'd0;
        bus.in_data  = exp_bp;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // cycle 1 after accept: new data offered while busy
        bus.in_data = {16'sd1111, 16'sd2222};
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_calc1: ready=%b valid=%b, want 0 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_calc2: ready=%b valid=%b, want 0 0", bus.in_ready, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_bp) begin
            errors++;
            $display("FAIL bypass_out: valid=%b data=%h, want 1 %h", bus.out_valid, bus.out_data, exp_bp);
        end
        $display("frame mode=0 filter=0 in=(4277,-4277) out=%h", bus.out_data);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL bypass_no_extra: pulses=%0d, want 0", extra);
        end
    endtask

    task automatic test_impulse();
        logic signed [15:0] y0, y1;
        int lat;
        int exp_y [5] = '{1024, 3072, 3840, 3072, 2112};
        for (int n = 0; n < 5; n++) begin
            run_frame(2'd1, 3'd3, (n == 0) ? 16'sd16384 : 16'sd0, 16'sd0, y0, y1, lat);
            checks++;
            if (int'(y0) !== exp_y[n] || y1 !== 16'sd0 || lat !== 3) begin
                errors++;
                $display("FAIL impulse[%0d]: ch0=%0d ch1=%0d lat=%0d, want %0d 0 3",
                         n, y0, y1, lat, exp_y[n]);
            end
        end
    endtask

    task automatic test_hp_dc();
        logic signed [15:0] y0, y1;
        int lat;
        longint mx1, mx2, my1, my2, ye;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        for (int n = 0; n < 200; n++) begin
            run_frame(2'd2, 3'd3, 16'sd16384, 16'sd0, y0, y1, lat);
            ye  = ref_step(9216, -18432, 9216, -16384, 4096, 16384, mx1, mx2, my1, my2);
            mx2 = mx1; mx1 = 16384; my2 = my1; my1 = ye;
            checks++;
            if (longint'(y0) !== ye || y1 !== 16'sd0) begin
                errors++;
                $display("FAIL hp_dc[%0d]: ch0=%0d ch1=%0d, want %0d 0", n, y0, y1, ye);
            end
        end
        checks++;
        if (y0 > 16'sd2 || y0 < -16'sd2) begin
            errors++;
            $display("FAIL hp_dc_settled: ch0=%0d, want |ch0|<=2", y0);
        end
        run_frame(2'd1, 3'd3, 16'sd16384, 16'sd0, y0, y1, lat);
        checks++;
        if (y0 !== 16'sd1024 || lat !== 3) begin
            errors++;
            $display("FAIL mode_switch_fresh: ch0=%0d lat=%0d, want 1024 3", y0, lat);
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] y0, y1;
        int lat;
        run_frame(2'd1, 3'd0, S_MAX, S_MIN, y0, y1, lat);
        checks++;
        if (y0 !== S_MAX || y1 !== S_MIN) begin
            errors++;
            $display("FAIL sat_unity: ch0=%0d ch1=%0d, want 32767 -32768", y0, y1);
        end
        run_frame(2'd1, 3'd7, S_MAX, S_MIN, y0, y1, lat);
        checks++;
        if (y0 !== S_MAX || y1 !== S_MIN) begin
            errors++;
            $display("FAIL sat_gain_a: ch0=%0d ch1=%0d, want 32767 -32768", y0, y1);
        end
        run_frame(2'd1, 3'd7, S_MIN, S_MAX, y0, y1, lat);
        checks++;
        if (y0 !== S_MIN || y1 !== S_MAX) begin
            errors++;
            $display("FAIL sat_gain_b: ch0=%0d ch1=%0d, want -32768 32767", y0, y1);
        end
    endtask

    task automatic test_back_to_back();
        int last, pulses, w, late;
        bus.mode     = 2'd0;
        bus.filter   = 3'd0;
        bus.in_data  = {16'sd200, 16'sd100};
        bus.in_valid = 1'b1;
        last   = -1;
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                $display("stream pulse cycle=%0d data=%h", c, bus.out_data);
                if (last >= 0) begin
                    checks++;
                    if (c - last !== 3) begin
                        errors++;
                        $display("FAIL b2b_spacing: gap=%0d, want 3", c - last);
                    end
                end
                checks++;
                if (bus.out_data !== {16'sd200, 16'sd100}) begin
                    errors++;
                    $display("FAIL b2b_data: data=%h, want 00c80064", bus.out_data);
                end
                last = c;
                pulses++;
            end
        end
        checks++;
        if (pulses < 4) begin
            errors++;
            $display("FAIL b2b_count: pulses=%0d, want >=4", pulses);
        end
        w = 0;
        while (!bus.out_valid && w < 6) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_calc: ready=%b, want 0", bus.in_ready);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_async: ready=%b valid=%b data=%h, want 1 0 00000000",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
        bus.in_valid = 1'b0;
        late = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.out_valid) late++;
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.out_valid) late++;
        end
        checks++;
        if (late !== 0 || bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_no_output: pulses=%0d data=%h, want 0 00000000", late, bus.out_data);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_impulse();
        test_hp_dc();
        test_saturation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
